// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, opcode values, datapath mux selects and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_BEQ,
    S_ADDI_EX,
    S_ADDI_WB,
    S_JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ir_write and pc_write are requests; in a memory state they only take
  // effect in the cycle the access completes.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       jump;
    logic       pc_write;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Shared instruction/data memory handshake. mem_req, IorD and MemWrite are
// held stable until mem_ready is seen high in the same cycle as mem_req.
interface mips_mc_ctrl_if;
  logic mem_req;
  logic IorD;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output IorD, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input IorD, input MemWrite, output mem_ready);
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the current FSM state to the datapath control
// word. Purely combinational; gating by reset and mem_ready is done upstream.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      // Speculatively compute the branch target into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.jump     = 1'b1;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: state register, next-state logic, reset
// gating of all outputs, PC write enable and the retired-instruction counter.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RET_CNT_W = 32,
  parameter int OP_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 zero,
  mips_mc_ctrl_if.master       mem,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [1:0]           AluOp,
  output logic [1:0]           PCSrc,
  output logic                 Branch,
  output logic                 Jump,
  output logic                 pc_en,
  output logic                 illegal_op,
  output logic [RET_CNT_W-1:0] retired,
  output state_t               state_dbg
);

  state_t state, state_next;
  ctrl_t  ctrl_raw, ctrl;
  logic   retire;
  logic [RET_CNT_W-1:0] ret_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (mem.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_RTYPE_EX;
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADR:  state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem.mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem.mem_ready) state_next = S_FETCH;
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      default:    state_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl_raw)
  );

  assign ctrl = reset ? '0 : ctrl_raw;

  // A store retires in the cycle its memory write is accepted.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEM_WB, S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JMP: retire = 1'b1;
      S_MEM_WR: retire = mem.mem_ready;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       ret_q <= '0;
    else if (retire) ret_q <= ret_q + RET_CNT_W'(1);
  end

  assign mem.mem_req  = ctrl.mem_req;
  assign mem.IorD     = ctrl.iord;
  assign mem.MemWrite = ctrl.mem_write;
  assign IRWrite      = ctrl.ir_write & mem.mem_ready;
  assign RegDst       = ctrl.reg_dst;
  assign MemToReg     = ctrl.mem_to_reg;
  assign RegWrite     = ctrl.reg_write;
  assign AluSrcA      = ctrl.alu_src_a;
  assign AluSrcB      = ctrl.alu_src_b;
  assign AluOp        = ctrl.alu_op;
  assign PCSrc        = ctrl.pc_src;
  assign Branch       = ctrl.branch;
  assign Jump         = ctrl.jump;
  assign pc_en        = (ctrl.pc_write & (~ctrl.mem_req | mem.mem_ready)) |
                        (ctrl.branch & zero);
  assign illegal_op   = ~reset && (state == S_DECODE) && !op_known(6'(opcode));
  assign retired      = reset ? '0 : ret_q;
  assign state_dbg    = reset ? S_FETCH : state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: each driven cycle pushes its expected
// control word; a negedge monitor pops and compares against the DUT.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int W     = 22;
  localparam int RET_W = 4;

  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_BAD  = 6'b111111;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             IRWrite, RegDst, MemToReg, RegWrite, AluSrcA;
  logic [1:0]       AluSrcB, AluOp, PCSrc;
  logic             Branch, Jump, pc_en, illegal_op;
  logic [RET_W-1:0] retired;
  state_t           state_dbg;

  mips_mc_ctrl_if mif ();

  mips_mc_ctrl #(.RET_CNT_W(RET_W), .OP_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluOp      (AluOp),
    .PCSrc      (PCSrc),
    .Branch     (Branch),
    .Jump       (Jump),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0]     exp_q[$];
  string            name_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [RET_W-1:0] exp_ret = '0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs for one cycle, straight from the state output table.
  function automatic logic [W-1:0] expw(input string st, input logic rdy,
                                        input logic z, input logic [5:0] op,
                                        input logic [RET_W-1:0] ret);
    logic mreq, iord, mwr, irw, rdst, m2r, rwr, srca, br, jmp, pce, ill;
    logic [1:0] srcb, aop, psrc;
    {mreq, iord, mwr, irw, rdst, m2r, rwr, srca, br, jmp, pce, ill} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      "FETCH":    begin mreq = 1; irw = rdy; srcb = 2'b01; pce = rdy; end
      "DECODE":   begin srcb = 2'b11;
                    ill = !(op inside {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J}); end
      "MEM_ADR":  begin srca = 1; srcb = 2'b10; end
      "MEM_RD":   begin mreq = 1; iord = 1; end
      "MEM_WB":   begin rwr = 1; m2r = 1; end
      "MEM_WR":   begin mreq = 1; iord = 1; mwr = 1; end
      "RTYPE_EX": begin srca = 1; aop = 2'b10; end
      "RTYPE_WB": begin rwr = 1; rdst = 1; end
      "BEQ":      begin srca = 1; aop = 2'b01; psrc = 2'b01; br = 1; pce = z; end
      "ADDI_EX":  begin srca = 1; srcb = 2'b10; end
      "ADDI_WB":  begin rwr = 1; end
      "JMP":      begin psrc = 2'b10; jmp = 1; pce = 1; end
      default: ;
    endcase
    return {mreq, iord, mwr, irw, rdst, m2r, rwr, srca, srcb, aop, psrc,
            br, jmp, pce, ill, ret};
  endfunction

  // driver: one clock cycle of stimulus plus its expected response
  task automatic cyc(input string st, input logic rst, input logic rdy,
                     input logic z, input logic [5:0] op);
    reset = rst; mif.mem_ready = rdy; zero = z; opcode = op;
    if (rst) begin
      exp_q.push_back('0);
      name_q.push_back("RESET");
      exp_ret = '0;
    end else begin
      exp_q.push_back(expw(st, rdy, z, op, exp_ret));
      name_q.push_back(st);
      if (st == "MEM_WB" || st == "RTYPE_WB" || st == "BEQ" || st == "ADDI_WB" ||
          st == "JMP" || (st == "MEM_WR" && rdy))
        exp_ret = exp_ret + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits, input logic [5:0] op);
    repeat (waits) cyc("FETCH", 0, 0, rb(), op);
    cyc("FETCH", 0, 1, rb(), op);
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    fetch(fw, op);
    cyc("DECODE", 0, rb(), rb(), op);
    case (op)
      C_R:    begin cyc("RTYPE_EX", 0, rb(), rb(), op); cyc("RTYPE_WB", 0, rb(), rb(), op); end
      C_ADDI: begin cyc("ADDI_EX", 0, rb(), rb(), op); cyc("ADDI_WB", 0, rb(), rb(), op); end
      C_LW: begin
        cyc("MEM_ADR", 0, rb(), rb(), op);
        repeat (mw) cyc("MEM_RD", 0, 0, rb(), op);
        cyc("MEM_RD", 0, 1, rb(), op);
        cyc("MEM_WB", 0, rb(), rb(), op);
      end
      C_SW: begin
        cyc("MEM_ADR", 0, rb(), rb(), op);
        repeat (mw) cyc("MEM_WR", 0, 0, rb(), op);
        cyc("MEM_WR", 0, 1, rb(), op);
      end
      C_BEQ:  cyc("BEQ", 0, rb(), z, op);
      C_J:    cyc("JMP", 0, rb(), rb(), op);
      default: ;
    endcase
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, e;
      string nm;
      got = {mif.mem_req, mif.IorD, mif.MemWrite, IRWrite, RegDst, MemToReg,
             RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc, Branch, Jump, pc_en,
             illegal_op, retired};
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got=%h exp=%h (t=%0t)", nm, got, e, $time);
      end
    end
  end

  initial begin
    reset = 1'b1; mif.mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    @(posedge clk);
    #1;
    cyc("RST", 1, 0, 0, C_R);
    cyc("RST", 1, 1, 1, C_R);

    instr(C_R,    0, 0, 0);
    instr(C_LW,   0, 2, 0);
    instr(C_SW,   1, 1, 0);
    instr(C_BEQ,  0, 0, 1);
    instr(C_BEQ,  0, 0, 0);
    instr(C_ADDI, 0, 0, 0);
    instr(C_BAD,  0, 0, 0);

    // reset arrives while a load is waiting on memory
    fetch(0, C_LW);
    cyc("DECODE", 0, rb(), rb(), C_LW);
    cyc("MEM_ADR", 0, rb(), rb(), C_LW);
    cyc("MEM_RD", 0, 0, rb(), C_LW);
    repeat (3) cyc("RST", 1, rb(), rb(), C_LW);

    // 16 jumps wrap the 4-bit retired counter back to zero
    repeat (16) instr(C_J, 0, 0, 0);
    cyc("FETCH", 0, 0, rb(), C_J);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got=%0d pending exp=0 pending", exp_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath control strobes (RegDst, MemToReg, MemWrite, AluSrc, RegWrite, AluOp, Jump, Branch, plus the multi-cycle mux selects).
- Arbitrates the single shared instruction/data memory through a req/ready handshake and counts retired instructions.

Parameters:
- RET_CNT_W, 32, width of retired-instruction counter.
- OP_W, 6, opcode field width (instr[31:26]).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OP_W  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag for beq.
- mem_ready  in  1  shared memory completed the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemWrite  out  1  write strobe, meaningful only with mem_req.
- IRWrite  out  1  load instruction register.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- AluSrcA  out  1  0 = PC, 1 = A.
- AluSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- AluOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Branch  out  1  beq in progress.
- Jump  out  1  jump in progress.
- pc_en  out  1  PCWrite | (Branch & zero).
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- retired  out  RET_CNT_W  retired-instruction count.

Behaviour:
- Moore FSM, one state register, updated on posedge clk.
- Reset:
  - reset=1 at any cycle, including mid-access: next state FETCH, retired=0.
  - While reset=1, every output is forced to 0.
  - The first fetch request appears in the cycle after reset deasserts.
- States, outputs and transitions (any output not listed is 0):
  - FETCH: mem_req=1, IorD=0, IRWrite=mem_ready, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00, pc_en=mem_ready. Stay while !mem_ready; else DECODE.
  - DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target into ALUOut). Next by opcode:
    - 000000 -> RTYPE_EX
    - 100011 / 101011 -> MEM_ADR
    - 000100 -> BEQ
    - 001000 -> ADDI_EX
    - 000010 -> JMP
    - other -> FETCH, with illegal_op=1 for this cycle; not counted as retired.
  - MEM_ADR: AluSrcA=1, AluSrcB=10, AluOp=00. lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD: mem_req=1, IorD=1. Stay until mem_ready, then MEM_WB.
  - MEM_WB: RegWrite=1, RegDst=0, MemToReg=1 -> FETCH, retire.
  - MEM_WR: mem_req=1, IorD=1, MemWrite=1. Stay until mem_ready, then FETCH, retire in the mem_ready cycle.
  - RTYPE_EX: AluSrcA=1, AluSrcB=00, AluOp=10 -> RTYPE_WB.
  - RTYPE_WB: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH, retire.
  - BEQ: AluSrcA=1, AluSrcB=00, AluOp=01, PCSrc=01, Branch=1; pc_en=zero -> FETCH, retire.
  - ADDI_EX: AluSrcA=1, AluSrcB=10, AluOp=00 -> ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0 -> FETCH, retire.
  - JMP: PCSrc=10, Jump=1, pc_en=1 -> FETCH, retire.
- Latency with zero memory wait:
  - R/addi = 4 cycles; lw = 5; sw = 4; beq = 3; j = 3.
  - Each wait cycle with mem_ready=0 adds 1 cycle.
- Handshake:
  - mem_req, IorD and MemWrite are held stable while waiting.
  - mem_ready is ignored in states without mem_req.
- Retired counter: +1 on the cycle the instruction completes; wraps from all-ones to 0 silently.
- opcode is sampled only in DECODE and MEM_ADR; the IR is stable there by construction.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (12 states).
  - Opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - AluOp constants ALU_ADD, ALU_SUB, ALU_FUNCT.
  - AluSrcB and PCSrc select constants.
- One sub-module, mips_ctrl_outdec: a combinational state-to-control-word decoder.
- The top block keeps the state register, next-state logic, pc_en, reset gating and the counter.

Test Plan:
- Reset held 3 cycles mid-MEM_RD, then released -> all outputs 0 during reset; cycle after release is FETCH with mem_req=1, IorD=0; retired=0.
- opcode=000000, mem_ready=1 always -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB; RegWrite=1 and RegDst=1 in cycle 4; retired 0->1.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_req/IorD=1 held across the wait; MemToReg=1 and RegWrite=1 in MEM_WB.
- beq (000100), zero=1 then repeated with zero=0 -> pc_en=1 with PCSrc=01 in the BEQ cycle; then pc_en=0; 3 cycles each; retired +1 each.
- opcode=111111 -> illegal_op single pulse in DECODE; next state FETCH; retired unchanged.
- Preload retired=all-ones via a run of 2^RET_CNT_W instructions with RET_CNT_W overridden to 4 -> 16 j instructions give retired=0 (wrap).
